// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO pointer constants and Gray/binary helpers
package fifo_pkg;

  localparam int ADDRBITS = 8;
  localparam int PTRW     = ADDRBITS + 1;
  localparam int FUNCW    = 32;

  typedef logic [FUNCW-1:0] word_t;

  // Callers zero-extend narrower pointers; the upper result bits stay zero.
  function automatic word_t bin2gray(input word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t gray);
    word_t bin;
    bin = gray;
    for (int s = 1; s < FUNCW; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray to binary converter (XOR prefix chain)
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int W = PTRW
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/read_ptr_empty.sv
// rtl/read_ptr_empty.sv - read-domain pointer, empty/almost-empty, occupancy and underflow
module read_ptr_empty
  import fifo_pkg::*;
#(
  parameter int addrbits  = ADDRBITS,
  parameter int ae_thresh = 4
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                flush,
  input  logic                rd_en,
  input  logic [addrbits:0]   sync_wrptr,
  output logic [addrbits-1:0] rdaddr,
  output logic [addrbits:0]   rdptr,
  output logic                empty,
  output logic                almost_empty,
  output logic [addrbits:0]   rd_count,
  output logic                underflow
);

  localparam int PW = addrbits + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] count_next;
  logic          rd_fire;
  logic          empty_next;
  logic          ae_next;
  word_t         gray_w;

  gray_to_bin #(.W(PW)) u_wr_g2b (
    .gray (sync_wrptr),
    .bin  (wbin)
  );

  // Compare in the full function width so the zero upper bits are checked too.
  always_comb begin
    rd_fire    = rd_en & ~empty;
    rbin_next  = rbin + {{addrbits{1'b0}}, rd_fire};
    gray_w     = bin2gray(word_t'(rbin_next));
    rgray_next = gray_w[PW-1:0];
    empty_next = (gray_w == word_t'(sync_wrptr));
    count_next = wbin - rbin_next;
    ae_next    = (word_t'(count_next) <= word_t'(ae_thresh));
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rbin         <= '0;
      rdptr        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else if (flush) begin
      rbin         <= '0;
      rdptr        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rdptr        <= rgray_next;
      empty        <= empty_next;
      almost_empty <= ae_next;
      rd_count     <= count_next;
      underflow    <= rd_en & empty;
    end
  end

  assign rdaddr = rbin[addrbits-1:0];

endmodule

// File: tb/tb_read_ptr_empty.sv
// tb/tb_read_ptr_empty.sv - directed self-checking bench for read_ptr_empty (depth 8)
module tb_read_ptr_empty;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       flush;
  logic       rd_en;
  logic [3:0] sync_wrptr;
  logic [2:0] rdaddr;
  logic [3:0] rdptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  read_ptr_empty #(.addrbits(3), .ae_thresh(2)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .flush        (flush),
    .rd_en        (rd_en),
    .sync_wrptr   (sync_wrptr),
    .rdaddr       (rdaddr),
    .rdptr        (rdptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] a, input logic [3:0] p,
                         input logic e, input logic ae, input logic [3:0] c, input logic u);
    chk({tag, ".rdaddr"}, 32'(rdaddr), 32'(a));
    chk({tag, ".rdptr"}, 32'(rdptr), 32'(p));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".rd_count"}, 32'(rd_count), 32'(c));
    chk({tag, ".underflow"}, 32'(underflow), 32'(u));
  endtask

  logic [2:0] wrap_addr [7]  = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [3:0] wrap_ptr  [7]  = '{4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010};
  logic [3:0] wrap_cnt  [7]  = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
  logic [3:0] wrap_sync [7]  = '{4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1010, 4'b1010, 4'b1010};

  initial begin
    rst        = 1'b0;
    flush      = 1'b0;
    rd_en      = 1'b0;
    sync_wrptr = 4'b0000;

    // 1. reset held with clock running, then released
    step();
    step();
    chk_all("reset", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    rst = 1'b1;
    step();
    chk_all("post_reset", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);

    // 2. five entries visible, drain back-to-back
    sync_wrptr = 4'b0111;
    step();
    chk_all("fill5", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd5, 1'b0);
    rd_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] kb;
      kb = 4'(k);
      step();
      chk("drain.rdaddr", 32'(rdaddr), 32'(k));
      chk("drain.rdptr", 32'(rdptr), 32'(kb ^ (kb >> 1)));
      chk("drain.rd_count", 32'(rd_count), 32'(5 - k));
      chk("drain.empty", 32'(empty), 32'(k == 5));
      chk("drain.almost_empty", 32'(almost_empty), 32'((5 - k) <= 2));
      chk("drain.underflow", 32'(underflow), 32'(0));
    end
    rd_en = 1'b0;
    step();

    // 3. wrap: pointers cross 7 -> 0 while the write pointer advances to 12
    sync_wrptr = 4'b1100;
    step();
    chk("wrap_pre.rd_count", 32'(rd_count), 32'(3));
    chk("wrap_pre.empty", 32'(empty), 32'(0));
    rd_en = 1'b1;
    for (int j = 0; j < 7; j++) begin
      sync_wrptr = wrap_sync[j];
      step();
      chk("wrap.rdaddr", 32'(rdaddr), 32'(wrap_addr[j]));
      chk("wrap.rdptr", 32'(rdptr), 32'(wrap_ptr[j]));
      chk("wrap.rd_count", 32'(rd_count), 32'(wrap_cnt[j]));
      chk("wrap.empty", 32'(empty), 32'(j == 6));
    end
    rd_en = 1'b0;
    step();

    // 4. underflow pulse, pointers frozen
    rd_en = 1'b1;
    step();
    chk_all("underflow", 3'd4, 4'b1010, 1'b1, 1'b1, 4'd0, 1'b1);
    rd_en = 1'b0;
    step();
    chk_all("underflow_end", 3'd4, 4'b1010, 1'b1, 1'b1, 4'd0, 1'b0);

    // 5. flush with three pending and rd_en asserted
    sync_wrptr = 4'b1000;
    step();
    chk("flush_pre.rd_count", 32'(rd_count), 32'(3));
    chk("flush_pre.empty", 32'(empty), 32'(0));
    flush = 1'b1;
    rd_en = 1'b1;
    step();
    chk_all("flush", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    flush      = 1'b0;
    rd_en      = 1'b0;
    sync_wrptr = 4'b0000;
    step();
    chk_all("post_flush", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);

    // 6. full occupancy, one read, then asynchronous reset between edges
    sync_wrptr = 4'b1100;
    step();
    chk_all("full", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0);
    rd_en = 1'b1;
    step();
    chk_all("full_rd", 3'd1, 4'b0001, 1'b0, 1'b0, 4'd7, 1'b0);
    rst = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    rd_en = 1'b0;
    step();
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_ptr_empty.md
Name: read_ptr_empty

Overview:
Read-domain pointer and empty-flag controller of the asynchronous FIFO. It consumes the Gray-coded write pointer after it has crossed into the read clock domain through the two-flop synchroniser. It then maintains the binary read address and the Gray read pointer, and generates empty, almost_empty, occupancy count and underflow. The Gray read pointer feeds the read-to-write synchroniser, and the binary address drives the dual-port RAM read port.

Parameters:
- addrbits, 8: RAM address width; FIFO depth = 2**addrbits; pointers are addrbits+1 bits (extra wrap bit).
- ae_thresh, 4: almost_empty asserts when occupancy <= ae_thresh; legal range 0 .. 2**addrbits-1.

Ports:
- clk_in, input, 1: read-domain clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of the read side, active-high.
- rd_en, input, 1: read request from the consumer.
- sync_wrptr, input, addrbits+1: Gray write pointer, already synchronised to clk_in.
- rdaddr, output, addrbits: binary RAM read address, equal to rbin[addrbits-1:0].
- rdptr, output, addrbits+1: registered Gray read pointer, sent to the write-domain synchroniser.
- empty, output, 1: registered FIFO-empty flag.
- almost_empty, output, 1: registered, occupancy <= ae_thresh.
- rd_count, output, addrbits+1: registered occupancy as seen from the read domain, range 0 .. 2**addrbits.
- underflow, output, 1: one-cycle pulse, rd_en while empty.

Behaviour:
- Reset is rst asynchronous and active-low; the clock is clk_in.
- Reset values:
  - internal rbin = 0, rdptr = 0, rdaddr = 0
  - empty = 1, almost_empty = 1
  - rd_count = 0, underflow = 0
- Flush is synchronous. It applies the reset values on the next edge, overrides rd_en, and suppresses underflow that cycle.
- Read acceptance:
  - rd_fire = rd_en & ~empty, using the registered empty.
  - rbin_next = rbin + rd_fire, modulo 2**(addrbits+1); the wrap bit toggles naturally.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - rbin and rdptr register rbin_next and rgray_next every edge.
- Data timing: rdaddr changes on the same edge the read is accepted. The RAM is addressed by rdaddr, so data for the current head is presented while rdaddr points at it. Accepting a read advances to the next entry; there is zero added latency beyond RAM read latency.
- empty_next = (rgray_next == sync_wrptr), i.e. a full (addrbits+1)-bit Gray compare. It is registered, so empty reflects the read issued in the same cycle with no bubble.
- Occupancy:
  - wbin = gray_to_bin(sync_wrptr).
  - count_next = wbin - rbin_next, modulo 2**(addrbits+1).
  - rd_count registers count_next.
  - almost_empty registers (count_next <= ae_thresh).
- Occupancy is pessimistic by the synchroniser delay: empty may deassert late but never early. A write is visible at the earliest 2 clk_in edges after the pointer leaves the write domain.
- underflow is registered (rd_en & empty & ~flush) and is a 1-cycle pulse; pointers do not move.
- Wrap-around: after 2**addrbits reads, rdaddr returns to 0 and the pointer MSB toggles. Empty detection stays correct because of the extra bit.
- Simultaneous read and sync_wrptr change: both are used in the same-cycle compare, with no priority issue.
- Flush must be asserted together with the write-side flush. After both clear, pointers equal 0 and empty = 1.
- rst asserted mid-read: outputs go to reset values immediately, without waiting for clk_in.

Decomposition:
- Shared package fifo_pkg:
  - function bin2gray(addrbits+1)
  - function gray2bin(addrbits+1)
  - pointer-width constant PTRW = addrbits+1
- Write-side pointer logic reuses the same package.
- Sub-module gray_to_bin: purely combinational, parameterised width, XOR prefix chain. It is instantiated once for sync_wrptr.

Test Plan:
All scenarios use addrbits = 3 (depth 8) and ae_thresh = 2.
1. Reset: hold rst = 0 with clocks running -> empty = 1, almost_empty = 1, rdptr = 0, rd_count = 0, underflow = 0. Release rst -> values unchanged.
2. Fill and drain: drive sync_wrptr = Gray(5) = 4'b0111, then read 5 times back-to-back.
   - rd_count reads 5, 4, 3, 2, 1, 0.
   - almost_empty rises when the count reaches 2.
   - empty = 1 on the edge of the 5th read.
   - rdaddr steps 0 to 5.
3. Wrap: step sync_wrptr through 12 Gray values while reading continuously.
   - rdaddr goes 7 -> 0.
   - rdptr MSB = 1 after 8 reads.
   - empty is correct when sync_wrptr = Gray(12) = 4'b1010 is fully drained.
4. Underflow: rd_en = 1 while empty -> underflow pulses exactly 1 cycle, rbin unchanged, rd_count = 0.
5. Flush: with 3 entries pending, assert flush and rd_en together -> next edge rdptr = 0, empty = 1, rd_count = 0, no underflow pulse.
6. Full occupancy: sync_wrptr = Gray(8) = 4'b1100 with rbin = 0 -> rd_count = 8, empty = 0, almost_empty = 0. Async rst mid-stream -> immediate return to reset values.
